jump_sequencer: RTL and testbench

//  Game-flow controller in front of the blocks layer stack. Accepts player jump requests,

---
 rtl/jump_sequencer_if.sv | 20 ++
 rtl/jump_sequencer.sv | 169 ++++++++++++++++
 tb/tb_jump_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/jump_sequencer_if.sv
// Strobe/layer bus between the jump sequencer and the blocks layer stack.
// The sequencer is the master; blocks returns jump_fail.
interface jump_sequencer_if;
    logic       jump_left;
    logic       jump_right;
    logic       load_layer;
    logic [0:6] layer_map;
    logic [0:6] block_type;
    logic       jump_fail;

    modport master (
        output jump_left, jump_right, load_layer, layer_map, block_type,
        input  jump_fail
    );

    modport slave (
        input  jump_left, jump_right, load_layer, layer_map, block_type,
        output jump_fail
    );
endinterface

// File: rtl/jump_sequencer.sv
// Game-flow controller: initial stack fill, jump request handling, shift wait,
// LFSR-generated layer loads, score counting and game-over latch.
module jump_sequencer #(
    parameter int unsigned NUM_LAYERS = 5,
    parameter int unsigned SHIFT_MS   = 200,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     module_en,
    input  logic                     one_ms_tick,
    input  logic                     btn_left,
    input  logic                     btn_right,
    jump_sequencer_if.master         blk,
    output logic                     busy,
    output logic                     game_over,
    output logic [15:0]              score
);

    localparam int unsigned FW = $clog2(2 * NUM_LAYERS + 1);
    localparam int unsigned CW = $clog2(SHIFT_MS + 1);

    typedef enum logic [2:0] {
        IDLE, FILL, READY, JUMP, CHECK, SHIFT, LOAD, OVER
    } state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [15:0]   score_q, score_d;
    logic [1:0]    btn_q, btn_d;
    logic [1:0]    rise_q, rise_d;
    logic          jump_left_q, jump_left_d;
    logic          jump_right_q, jump_right_d;
    logic          load_layer_q, load_layer_d;
    logic [0:6]    layer_map_q, layer_map_d;
    logic [0:6]    block_type_q, block_type_d;
    logic          busy_q, busy_d;
    logic          game_over_q, game_over_d;

    logic [0:6]    map_new, type_new;
    logic [2:0]    k;

    // Candidate layer; column k is forced safe so a landing spot always exists
    always_comb begin
        k        = (lfsr_q[2:0] == 3'd7) ? 3'd0 : lfsr_q[2:0];
        map_new  = lfsr_q[15:9];
        type_new = lfsr_q[8:2];
        map_new[k]  = 1'b1;
        type_new[k] = 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        cnt_d        = cnt_q;
        score_d      = score_q;
        jump_left_d  = 1'b0;
        jump_right_d = 1'b0;
        load_layer_d = 1'b0;
        layer_map_d  = layer_map_q;
        block_type_d = block_type_q;
        lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        btn_d        = {btn_left, btn_right};
        rise_d       = btn_d & ~btn_q;

        case (state_q)
            IDLE: begin
                state_d = FILL;
                fill_d  = '0;
            end
            FILL: begin
                load_layer_d = ~fill_q[0];
                fill_d       = fill_q + FW'(1);
                if (fill_q == FW'(2 * NUM_LAYERS - 1))
                    state_d = READY;
            end
            READY: begin
                // Simultaneous edges on both buttons are deliberately ignored
                if (rise_q == 2'b10) begin
                    state_d     = JUMP;
                    jump_left_d = 1'b1;
                end else if (rise_q == 2'b01) begin
                    state_d      = JUMP;
                    jump_right_d = 1'b1;
                end
            end
            JUMP: state_d = CHECK;
            CHECK: begin
                if (blk.jump_fail) begin
                    state_d = OVER;
                end else begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    if (score_q != 16'hFFFF)
                        score_d = score_q + 16'd1;
                end
            end
            SHIFT: begin
                if (one_ms_tick) begin
                    if (cnt_q == CW'(SHIFT_MS - 1)) begin
                        state_d      = LOAD;
                        load_layer_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            LOAD:    state_d = READY;
            OVER:    state_d = OVER;
            default: state_d = IDLE;
        endcase

        if (load_layer_d) begin
            layer_map_d  = map_new;
            block_type_d = type_new;
        end

        busy_d      = (state_d != READY);
        game_over_d = (state_d == OVER);
    end

    always_ff @(posedge clk) begin
        if (rst || !module_en) begin
            state_q      <= IDLE;
            fill_q       <= '0;
            cnt_q        <= '0;
            score_q      <= '0;
            btn_q        <= '0;
            rise_q       <= '0;
            jump_left_q  <= 1'b0;
            jump_right_q <= 1'b0;
            load_layer_q <= 1'b0;
            layer_map_q  <= '0;
            block_type_q <= '0;
            busy_q       <= 1'b1;
            game_over_q  <= 1'b0;
            // LFSR only reseeds on rst; a disable merely freezes it
            if (rst)
                lfsr_q <= LFSR_SEED;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            cnt_q        <= cnt_d;
            score_q      <= score_d;
            btn_q        <= btn_d;
            rise_q       <= rise_d;
            jump_left_q  <= jump_left_d;
            jump_right_q <= jump_right_d;
            load_layer_q <= load_layer_d;
            layer_map_q  <= layer_map_d;
            block_type_q <= block_type_d;
            busy_q       <= busy_d;
            game_over_q  <= game_over_d;
            lfsr_q       <= lfsr_d;
        end
    end

    assign blk.jump_left  = jump_left_q;
    assign blk.jump_right = jump_right_q;
    assign blk.load_layer = load_layer_q;
    assign blk.layer_map  = layer_map_q;
    assign blk.block_type = block_type_q;
    assign busy           = busy_q;
    assign game_over      = game_over_q;
    assign score          = score_q;

endmodule

// File: tb/tb_jump_sequencer.sv
// Directed-plus-random bench for jump_sequencer with a behavioural LFSR/layer
// model, a score model and an always-on strobe exclusivity monitor.
module tb_jump_sequencer;

    localparam int unsigned NL   = 5;
    localparam int unsigned SMS  = 5;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst, module_en, one_ms_tick, btn_left, btn_right;
    logic        busy, game_over;
    logic [15:0] score;

    jump_sequencer_if bus ();

    jump_sequencer #(.NUM_LAYERS(NL), .SHIFT_MS(SMS), .LFSR_SEED(SEED)) dut (
        .clk         (clk),
        .rst         (rst),
        .module_en   (module_en),
        .one_ms_tick (one_ms_tick),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .blk         (bus.master),
        .busy        (busy),
        .game_over   (game_over),
        .score       (score)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          n_jl  = 0;
    int          n_jr  = 0;
    int          n_ld  = 0;
    logic [15:0] exp_score;
    logic [15:0] m_lfsr = 16'h0;
    logic [15:0] m_prev = 16'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        int unsigned v, fb;
        v  = l;
        fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
        return 16'(((v << 1) | fb) & 32'hFFFF);
    endfunction

    // Expected layer: column c of map is LFSR bit 15-c, of type is bit 8-c
    function automatic void exp_layer(input logic [15:0] l, output logic [0:6] m, output logic [0:6] t);
        int unsigned v, kk;
        v  = l;
        kk = (v % 8) % 7;
        for (int c = 0; c < 7; c++) begin
            m[c] = 1'((v >> (15 - c)) & 1);
            t[c] = 1'((v >> (8 - c)) & 1);
        end
        m[kk] = 1'b1;
        t[kk] = 1'b1;
    endfunction

    always @(posedge clk) begin
        m_prev = m_lfsr;
        if (rst)            m_lfsr = SEED;
        else if (module_en) m_lfsr = lfsr_next(m_lfsr);
    end

    always @(negedge clk) begin
        logic [0:6] em, et;
        chk("strobe_exclusive", 32'(bus.jump_left) + 32'(bus.jump_right) + 32'(bus.load_layer) <= 1, 1);
        if (bus.jump_left)  n_jl++;
        if (bus.jump_right) n_jr++;
        if (bus.load_layer) begin
            n_ld++;
            exp_layer(m_prev, em, et);
            chk("layer_map", 32'(bus.layer_map), 32'(em));
            chk("block_type", 32'(bus.block_type), 32'(et));
            chk("layer_has_safe", 32'((bus.layer_map & bus.block_type) != 7'd0), 1);
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic do_fill();
        int ld0;
        ld0 = n_ld;
        module_en = 1'b1;
        for (int k = 0; k <= 2 * NL; k++) begin
            cyc();
            chk("fill_load", 32'(bus.load_layer), 32'((k % 2 == 1) && (k < 2 * NL)));
            chk("fill_busy", 32'(busy), 32'(k < 2 * NL));
        end
        chk("fill_count", 32'(n_ld - ld0), NL);
    endtask

    task automatic do_jump(input bit right, input bit fail, input bit poke_other);
        int sl, sr;
        if (right) btn_right = 1'b1; else btn_left = 1'b1;
        cyc();
        chk("edge_reg_no_strobe", 32'(bus.jump_left | bus.jump_right), 0);
        cyc();
        chk("jump_left", 32'(bus.jump_left), 32'(!right));
        chk("jump_right", 32'(bus.jump_right), 32'(right));
        bus.jump_fail = fail;
        cyc();
        chk("check_no_strobe", 32'(bus.jump_left | bus.jump_right), 0);
        btn_left = 1'b0;
        btn_right = 1'b0;
        cyc();
        bus.jump_fail = 1'b0;
        if (fail) begin
            chk("over_flag", 32'(game_over), 1);
            chk("over_score", 32'(score), 32'(exp_score));
            chk("over_busy", 32'(busy), 1);
            return;
        end
        if (exp_score != 16'hFFFF) exp_score = exp_score + 16'd1;
        chk("score", 32'(score), 32'(exp_score));
        chk("shift_busy", 32'(busy), 1);
        sl = n_jl;
        sr = n_jr;
        if (poke_other) begin
            if (right) btn_left = 1'b1; else btn_right = 1'b1;
        end
        for (int t = 0; t < int'(SMS); t++) begin
            int gap;
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                cyc();
                chk("shift_no_load", 32'(bus.load_layer), 0);
            end
            one_ms_tick = 1'b1;
            cyc();
            one_ms_tick = 1'b0;
            chk("load_after_tick", 32'(bus.load_layer), 32'(t == int'(SMS) - 1));
        end
        cyc();
        chk("ready_busy", 32'(busy), 0);
        chk("ready_no_load", 32'(bus.load_layer), 0);
        if (poke_other) begin
            repeat (3) cyc();
            chk("held_no_retrigger", 32'((n_jl - sl) + (n_jr - sr)), 0);
            btn_left = 1'b0;
            btn_right = 1'b0;
            cyc();
        end
    endtask

    initial begin
        int sl, sr;
        rst = 1'b1;
        module_en = 1'b0;
        one_ms_tick = 1'b0;
        btn_left = 1'b0;
        btn_right = 1'b0;
        bus.jump_fail = 1'b0;
        exp_score = 16'd0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        chk("rst_busy", 32'(busy), 1);
        chk("rst_over", 32'(game_over), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_strobes", 32'({bus.jump_left, bus.jump_right, bus.load_layer}), 0);
        chk("rst_map", 32'({bus.layer_map, bus.block_type}), 0);

        do_fill();
        do_jump(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            do_jump(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));

        // Both buttons rising together, then held
        sl = n_jl;
        sr = n_jr;
        btn_left = 1'b1;
        btn_right = 1'b1;
        repeat (6) cyc();
        chk("both_no_strobe", 32'((n_jl - sl) + (n_jr - sr)), 0);
        chk("both_ready", 32'(busy), 0);
        btn_left = 1'b0;
        btn_right = 1'b0;
        cyc();

        do_jump(1'b0, 1'b0, 1'b1);

        do_jump(1'b0, 1'b1, 1'b0);
        sl = n_jl;
        sr = n_jr;
        for (int i = 0; i < 4; i++) begin
            btn_left = 1'(i % 2);
            btn_right = 1'((i + 1) % 2);
            repeat (3) cyc();
        end
        btn_left = 1'b0;
        btn_right = 1'b0;
        cyc();
        chk("over_no_strobe", 32'((n_jl - sl) + (n_jr - sr)), 0);
        chk("over_stays", 32'(game_over), 1);
        chk("over_score_frozen", 32'(score), 32'(exp_score));

        module_en = 1'b0;
        cyc();
        exp_score = 16'd0;
        chk("dis_over", 32'(game_over), 0);
        chk("dis_score", 32'(score), 0);
        do_fill();

        // Saturation: preload the score register just below the limit
        force dut.score_q = 16'hFFFE;
        cyc();
        release dut.score_q;
        exp_score = 16'hFFFE;
        do_jump(1'b1, 1'b0, 1'b0);
        do_jump(1'b0, 1'b0, 1'b0);
        chk("sat_score", 32'(score), 32'hFFFF);

        // Disable mid-SHIFT
        btn_right = 1'b1;
        repeat (2) cyc();
        btn_right = 1'b0;
        repeat (3) cyc();
        module_en = 1'b0;
        cyc();
        exp_score = 16'd0;
        chk("dis_shift_busy", 32'(busy), 1);
        chk("dis_shift_score", 32'(score), 0);
        chk("dis_shift_strobes", 32'({bus.jump_left, bus.jump_right, bus.load_layer}), 0);
        do_fill();

        // Disable while a jump strobe is high
        btn_left = 1'b1;
        repeat (2) cyc();
        chk("pre_dis_strobe", 32'(bus.jump_left), 1);
        module_en = 1'b0;
        btn_left = 1'b0;
        cyc();
        chk("dis_strobe_drop", 32'(bus.jump_left), 0);
        chk("dis_strobe_busy", 32'(busy), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
